// File: rtl/mul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_ctrl_pkg
// Shared definitions for the two-requester multiplier sharing controller:
//   - XLEN      : operand / result width of the shared multiplier (32)
//   - op_e      : RISC-V M-extension multiply encodings
//   - owner_t   : index of the requester that owns an in-flight op
//   - fix_result: turns the signed 64-bit product into the op's 32-bit result
// ---------------------------------------------------------------------------
package mul_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_e;

   // Requester index: 0 = lane 0, 1 = lane 1.
   typedef logic owner_t;

   // The multiplier always computes signed(a) * signed(b). Reinterpreting an
   // operand as unsigned adds (other operand << 32) whenever its top bit is
   // set, so the unsigned variants only need additive fixes on the high half.
   function automatic logic [XLEN-1:0] fix_result(
      input op_e              op,
      input logic [2*XLEN-1:0] p,
      input logic [XLEN-1:0]   a,
      input logic [XLEN-1:0]   b
   );
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] add_a;
      logic [XLEN-1:0] add_b;
      hi    = p[2*XLEN-1:XLEN];
      add_a = b[XLEN-1] ? a : '0;   // b treated as unsigned
      add_b = a[XLEN-1] ? b : '0;   // a treated as unsigned
      case (op)
         OP_MUL:    fix_result = p[XLEN-1:0];
         OP_MULH:   fix_result = hi;
         OP_MULHSU: fix_result = hi + add_a;
         default:   fix_result = hi + add_a + add_b;
      endcase
   endfunction

endpackage

// File: rtl/booth_wallace_multiplier.sv
// ---------------------------------------------------------------------------
// booth_wallace_multiplier
// Combinational signed XLEN x XLEN multiplier.
//   a, b : signed operands (two's complement)
//   p    : full 2*XLEN-bit signed product
// Radix-4 Booth recoding of b yields XLEN/2 partial products, which are
// folded through a carry-save (3:2) chain and resolved by one final adder.
// ---------------------------------------------------------------------------
module booth_wallace_multiplier
   import mul_ctrl_pkg::*;
(
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] p
);

   localparam int NPP = XLEN / 2;
   localparam int PW  = 2 * XLEN;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] a_dbl;
   logic [XLEN:0] b_ext;          // b with the implicit b[-1] = 0 appended

   assign a_ext = {{XLEN{a[XLEN-1]}}, a};
   assign a_dbl = {a_ext[PW-2:0], 1'b0};
   assign b_ext = {b, 1'b0};

   logic [PW-1:0] pp     [NPP];
   logic [PW-1:0] csa_s  [NPP+1];
   logic [PW-1:0] csa_c  [NPP+1];

   assign csa_s[0] = '0;
   assign csa_c[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NPP; gi++) begin : g_pp
         logic [2:0]    digit;
         logic [PW-1:0] mag;

         // Booth digit = -2*b[2i+1] + b[2i] + b[2i-1], in {-2..2}
         assign digit = b_ext[2*gi+2 -: 3];

         always_comb begin
            mag = '0;
            case (digit)
               3'b001, 3'b010: mag = a_ext;
               3'b011:         mag = a_dbl;
               3'b100:         mag = -a_dbl;
               3'b101, 3'b110: mag = -a_ext;
               default:        mag = '0;
            endcase
         end

         assign pp[gi] = mag << (2 * gi);

         // 3:2 compressor folding this partial product into the running pair
         assign csa_s[gi+1] = csa_s[gi] ^ csa_c[gi] ^ pp[gi];
         assign csa_c[gi+1] = ((csa_s[gi] & csa_c[gi]) |
                               (csa_s[gi] & pp[gi])    |
                               (csa_c[gi] & pp[gi])) << 1;
      end
   endgenerate

   // Everything is modulo 2^PW, so the sign extensions wrap correctly.
   assign p = csa_s[NPP] + csa_c[NPP];

endmodule

// File: rtl/mul_rr_arb2.sv
// ---------------------------------------------------------------------------
// mul_rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   valid[1:0] : request lines
//   fire       : a granted request was actually accepted this cycle
//   grant[1:0] : one-hot grant (zero when nobody requests)
// The priority pointer moves only on fire, so a grant that was not taken
// (downstream full) keeps its priority for the next cycle.
// ---------------------------------------------------------------------------
module mul_rr_arb2
   import mul_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       fire,
   output logic [1:0] grant
);

   owner_t prio_reg;     // requester that wins when both are valid
   owner_t prio_next;

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = prio_reg ? 2'b10 : 2'b01;
      end
   end

   // After a handshake the loser of that grant gets priority.
   always_comb begin
      prio_next = prio_reg;
      if (fire) begin
         prio_next = grant[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_reg <= 1'b0;
      end else begin
         prio_reg <= prio_next;
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl
// Shares one combinational signed multiplier between two requesters.
//   clk, rst_n          : clock, synchronous active-low reset
//   reqN_valid/ready    : request handshake for lane N (N = 0, 1)
//   reqN_op/a/b/tag     : operation, operands and opaque tag
//   rspN_valid/ready    : response handshake for lane N
//   rspN_data/tag       : result and the tag of the producing request
//   busy                : either pipeline stage holds an op
// Pipeline: S1 registers the granted request and feeds the multiplier;
// the op-dependent correction is registered into S2, which drives the
// response channel of the op's owner. Responses leave in issue order.
// ---------------------------------------------------------------------------
module mul_share_ctrl #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   input  logic [TAG_W-1:0] req1_tag,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [XLEN-1:0]  rsp0_data,
   output logic [TAG_W-1:0] rsp0_tag,

   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [XLEN-1:0]  rsp1_data,
   output logic [TAG_W-1:0] rsp1_tag,

   output logic             busy
);

   // ---------------- stage registers ----------------
   logic                   s1_valid_reg;
   logic [XLEN-1:0]        s1_a_reg;
   logic [XLEN-1:0]        s1_b_reg;
   mul_ctrl_pkg::op_e      s1_op_reg;
   logic [TAG_W-1:0]       s1_tag_reg;
   mul_ctrl_pkg::owner_t   s1_owner_reg;

   logic                   s2_valid_reg;
   logic [XLEN-1:0]        s2_data_reg;
   logic [TAG_W-1:0]       s2_tag_reg;
   mul_ctrl_pkg::owner_t   s2_owner_reg;

   // ---------------- flow control ----------------
   logic       s2_pop;
   logic       s1_advance;
   logic       can_accept;
   logic [1:0] grant;
   logic       fire;
   logic       sel_rsp_ready;

   assign sel_rsp_ready = s2_owner_reg ? rsp1_ready : rsp0_ready;
   assign s2_pop        = s2_valid_reg & sel_rsp_ready;
   assign s1_advance    = s1_valid_reg & (~s2_valid_reg | s2_pop);
   assign can_accept    = ~s1_valid_reg | s1_advance;

   // grant is already qualified by valid, so ready never appears alone.
   assign req0_ready = grant[0] & can_accept;
   assign req1_ready = grant[1] & can_accept;
   assign fire       = req0_ready | req1_ready;

   mul_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid ({req1_valid, req0_valid}),
      .fire  (fire),
      .grant (grant)
   );

   // ---------------- request mux into S1 ----------------
   logic [XLEN-1:0]      s1_a_next;
   logic [XLEN-1:0]      s1_b_next;
   mul_ctrl_pkg::op_e    s1_op_next;
   logic [TAG_W-1:0]     s1_tag_next;
   mul_ctrl_pkg::owner_t s1_owner_next;

   always_comb begin
      s1_owner_next = grant[1];
      if (grant[1]) begin
         s1_a_next   = req1_a;
         s1_b_next   = req1_b;
         s1_op_next  = mul_ctrl_pkg::op_e'(req1_op);
         s1_tag_next = req1_tag;
      end else begin
         s1_a_next   = req0_a;
         s1_b_next   = req0_b;
         s1_op_next  = mul_ctrl_pkg::op_e'(req0_op);
         s1_tag_next = req0_tag;
      end
   end

   // ---------------- shared multiplier + correction ----------------
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   s2_data_next;

   booth_wallace_multiplier u_mul (
      .a (s1_a_reg),
      .b (s1_b_reg),
      .p (product)
   );

   assign s2_data_next = mul_ctrl_pkg::fix_result(s1_op_reg, product,
                                                   s1_a_reg, s1_b_reg);

   // ---------------- sequential state ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_op_reg    <= mul_ctrl_pkg::OP_MUL;
         s1_tag_reg   <= '0;
         s1_owner_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
         s2_tag_reg   <= '0;
         s2_owner_reg <= 1'b0;
      end else begin
         // S1: a new accept overwrites; otherwise drain if moved on.
         if (fire) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= s1_a_next;
            s1_b_reg     <= s1_b_next;
            s1_op_reg    <= s1_op_next;
            s1_tag_reg   <= s1_tag_next;
            s1_owner_reg <= s1_owner_next;
         end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
         end

         // S2: load on advance (covers pop+load on one edge, no bubble);
         // payload is left untouched while stalled so it stays stable.
         if (s1_advance) begin
            s2_valid_reg <= 1'b1;
            s2_data_reg  <= s2_data_next;
            s2_tag_reg   <= s1_tag_reg;
            s2_owner_reg <= s1_owner_reg;
         end else if (s2_pop) begin
            s2_valid_reg <= 1'b0;
         end
      end
   end

   // ---------------- response channels ----------------
   assign rsp0_valid = s2_valid_reg & ~s2_owner_reg;
   assign rsp1_valid = s2_valid_reg &  s2_owner_reg;
   assign rsp0_data  = s2_data_reg;
   assign rsp1_data  = s2_data_reg;
   assign rsp0_tag   = s2_tag_reg;
   assign rsp1_tag   = s2_tag_reg;

   assign busy = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_mul_share_ctrl.sv
module tb_mul_share_ctrl;

   localparam logic [1:0] MUL    = 2'b00;
   localparam logic [1:0] MULH   = 2'b01;
   localparam logic [1:0] MULHSU = 2'b10;
   localparam logic [1:0] MULHU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_tag, req1_tag;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic [3:0]  rsp0_tag, rsp1_tag;
   logic        busy;

   always #5 clk = ~clk;

   mul_share_ctrl #(.TAG_W(4), .XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_tag   (req0_tag),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_tag   (req1_tag),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .rsp0_tag   (rsp0_tag),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data),
      .rsp1_tag   (rsp1_tag),
      .busy       (busy)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      int          slot;
   } exp_t;

   exp_t exp0_q[$];
   exp_t exp1_q[$];
   int   grant_log[$];

   int          checks   = 0;
   int          failures = 0;
   int          slot     = 0;
   logic        lat_strict = 1'b1;
   logic        hs0, hs1;
   logic [31:0] pend_exp0, pend_exp1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h (slot %0d)", tag, obs, exp, slot);
      end
   endtask

   // Independent reference: extend operands per op signedness and multiply.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, prod;
      sa = {{32{a[31]}}, a};
      ua = {32'b0, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (op)
         MUL:     prod = sa * sb;
         MULH:    prod = sa * sb;
         MULHSU:  prod = sa * ub;
         default: prod = ua * ub;
      endcase
      return (op == MUL) ? prod[31:0] : prod[63:32];
   endfunction

   task automatic check_rsp(input int ch, input logic [31:0] data, input logic [3:0] tag);
      exp_t e;
      if ((ch == 0 && exp0_q.size() == 0) || (ch == 1 && exp1_q.size() == 0)) begin
         check($sformatf("rsp%0d_spurious", ch), 1, 0);
      end else begin
         if (ch == 0) e = exp0_q.pop_front();
         else         e = exp1_q.pop_front();
         check($sformatf("rsp%0d_data", ch), data, e.data);
         check($sformatf("rsp%0d_tag", ch), tag, e.tag);
         if (lat_strict) check($sformatf("rsp%0d_latency", ch), slot - e.slot, 2);
         $display("rsp%0d slot=%0d data=0x%08h tag=%0d", ch, slot, data, tag);
      end
   endtask

   // One clock slot: sample #1 after the falling edge, record handshakes,
   // then advance to the next falling edge.
   task automatic cycle();
      exp_t e;
      #1;
      hs0 = rst_n && req0_valid && req0_ready;
      hs1 = rst_n && req1_valid && req1_ready;
      if (rst_n) begin
         check("ready_excl", {61'b0, req0_ready & req1_ready,
                              req0_ready & ~req0_valid, req1_ready & ~req1_valid}, 0);
         if (hs0) begin
            e.data = pend_exp0; e.tag = req0_tag; e.slot = slot;
            exp0_q.push_back(e);
            grant_log.push_back(0);
            $display("req0 slot=%0d op=%0d a=0x%08h b=0x%08h tag=%0d", slot, req0_op, req0_a, req0_b, req0_tag);
         end
         if (hs1) begin
            e.data = pend_exp1; e.tag = req1_tag; e.slot = slot;
            exp1_q.push_back(e);
            grant_log.push_back(1);
            $display("req1 slot=%0d op=%0d a=0x%08h b=0x%08h tag=%0d", slot, req1_op, req1_a, req1_b, req1_tag);
         end
         if (rsp0_valid && rsp0_ready) check_rsp(0, rsp0_data, rsp0_tag);
         if (rsp1_valid && rsp1_ready) check_rsp(1, rsp1_data, rsp1_tag);
      end
      @(posedge clk);
      @(negedge clk);
      slot++;
   endtask

   task automatic set_req(input int ch, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
      if (ch == 0) begin
         req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; pend_exp0 = exp; req0_valid = 1'b1;
      end else begin
         req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; pend_exp1 = exp; req1_valid = 1'b1;
      end
   endtask

   task automatic new_op(input int ch);
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      set_req(ch, op, a, b, 4'($urandom_range(0, 15)), model(op, a, b));
   endtask

   task automatic issue(input int ch, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
      logic got;
      got = 1'b0;
      set_req(ch, op, a, b, tag, exp);
      for (int i = 0; i < 20; i++) begin
         cycle();
         if ((ch == 0) ? hs0 : hs1) begin
            got = 1'b1;
            break;
         end
      end
      check($sformatf("issue%0d_handshake", ch), got, 1);
      if (ch == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = MUL; req0_a = '0; req0_b = '0; req0_tag = '0;
      req1_op = MUL; req1_a = '0; req1_b = '0; req1_tag = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      pend_exp0 = '0; pend_exp1 = '0;
      set_req(0, MUL, 32'd7, 32'd9, 4'd3, 32'd63);

      // ---- reset with a pending request ----
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rst_rsp0_valid", rsp0_valid, 0);
         check("rst_rsp1_valid", rsp1_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_rsp0_data", rsp0_data, 0);
         check("rst_rsp1_tag", rsp1_tag, 0);
         cycle();
      end
      rst_n = 1'b1;
      #1 check("first_grant_req0", req0_ready, 1);

      // ---- single MUL on lane 0 ----
      issue(0, MUL, 32'd7, 32'd9, 4'd3, 32'd63);
      repeat (4) cycle();

      // ---- lane 1 signed variants back to back ----
      issue(1, MULH,   32'h8000_0000, 32'h8000_0000, 4'd1, 32'h4000_0000);
      issue(1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
      issue(1, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF);
      issue(1, MUL,    32'hFFFF_FFE7, 32'hFFFF_FFF3, 4'd4, 32'd325);
      repeat (4) cycle();

      // ---- both lanes contending: round-robin alternation ----
      grant_log.delete();
      n0 = 0; n1 = 0;
      new_op(0);
      new_op(1);
      for (int i = 0; i < 20 && (n0 < 3 || n1 < 3); i++) begin
         cycle();
         if (hs0) begin
            n0++;
            if (n0 < 3) new_op(0); else req0_valid = 1'b0;
         end
         if (hs1) begin
            n1++;
            if (n1 < 3) new_op(1); else req1_valid = 1'b0;
         end
      end
      check("rr_count", n0 + n1, 6);
      for (int i = 0; i < grant_log.size(); i++) begin
         check($sformatf("rr_order%0d", i), grant_log[i], i % 2);
      end
      repeat (4) cycle();

      // ---- backpressure: lane 0 result stalls in S2, lane 1 op in S1 ----
      lat_strict = 1'b0;
      rsp0_ready = 1'b0;
      issue(0, MULHU, 32'h8000_0000, 32'd3,         4'd5, 32'h0000_0001);
      issue(1, MULH,  32'h8000_0000, 32'h7FFF_FFFF, 4'd6, 32'hC000_0000);
      new_op(0);
      new_op(1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_req0_ready", req0_ready, 0);
         check("bp_req1_ready", req1_ready, 0);
         check("bp_rsp0_valid", rsp0_valid, 1);
         check("bp_rsp1_valid", rsp1_valid, 0);
         check("bp_rsp0_data", rsp0_data, 32'h0000_0001);
         check("bp_rsp0_tag", rsp0_tag, 4'd5);
         cycle();
      end
      rsp0_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (hs0) req0_valid = 1'b0;
         if (hs1) req1_valid = 1'b0;
         if (!req0_valid && !req1_valid && exp0_q.size() == 0 && exp1_q.size() == 0) break;
      end
      check("bp_drain_q0", exp0_q.size(), 0);
      check("bp_drain_q1", exp1_q.size(), 0);
      lat_strict = 1'b1;
      repeat (2) cycle();

      // ---- reset with both stages full ----
      rsp0_ready = 1'b0;
      issue(0, MUL, 32'd5, 32'd6, 4'd1, 32'd30);
      issue(0, MUL, 32'd2, 32'd3, 4'd2, 32'd6);
      #1;
      check("pre_rst_busy", busy, 1);
      check("pre_rst_rsp0_valid", rsp0_valid, 1);
      rst_n = 1'b0;
      cycle();
      exp0_q.delete();
      exp1_q.delete();
      #1;
      check("mid_rst_rsp0_valid", rsp0_valid, 0);
      check("mid_rst_rsp1_valid", rsp1_valid, 0);
      check("mid_rst_busy", busy, 0);
      rst_n = 1'b1;
      rsp0_ready = 1'b1;
      repeat (6) cycle();
      #1;
      check("post_rst_busy", busy, 0);
      check("final_q0_empty", exp0_q.size(), 0);
      check("final_q1_empty", exp1_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
